axi_line_ctrl: RTL and testbench

Cache-line transfer controller between the cache's miss/eviction logic and the cache's AXI4 master port. Each command optionally writes back one dirty line as a write burst, then refills one line as a read burst. Both bursts are fixed-length INCR bursts of `LINE_BEATS` beats. The block is the single owner of the `M_AXI_*` channels and allows one command in flight at a time.

---
 rtl/axi_line_if.sv | 39 +++
 rtl/axi_line_ctrl.sv | 122 ++++++++++++
 tb/tb_axi_line_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/axi_line_if.sv
// axi_line_if: AXI4 read/write channel bundle between a line controller (master) and its slave.
interface axi_line_if #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int IW = 4
);
  logic [AW-1:0]   awaddr;
  logic            awvalid, awready;
  logic [IW-1:0]   awid;
  logic [1:0]      awburst;
  logic [2:0]      awsize;
  logic [7:0]      awlen;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid, wready, wlast;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic [IW-1:0]   bid;
  logic [AW-1:0]   araddr;
  logic            arvalid, arready;
  logic [IW-1:0]   arid;
  logic [1:0]      arburst;
  logic [2:0]      arsize;
  logic [7:0]      arlen;
  logic            rvalid, rready, rlast;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic [IW-1:0]   rid;
  modport master (
    output awaddr, awvalid, awid, awburst, awsize, awlen, wdata, wstrb, wvalid, wlast, bready,
           araddr, arvalid, arid, arburst, arsize, arlen, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
  );
  modport slave (
    input  awaddr, awvalid, awid, awburst, awsize, awlen, wdata, wstrb, wvalid, wlast, bready,
           araddr, arvalid, arid, arburst, arsize, arlen, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
  );
endinterface

// File: rtl/axi_line_ctrl.sv
// axi_line_ctrl: optional dirty-line writeback burst followed by a line refill burst on an AXI4 master.
module axi_line_ctrl #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int LINE_BEATS     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_wb_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_wb_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_fill_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]     wb_data_i,
  input  logic                          wb_valid_i,
  output logic                          wb_ready_o,
  output logic [AXI_DATA_WIDTH-1:0]     fill_data_o,
  output logic                          fill_valid_o,
  output logic [$clog2(LINE_BEATS)-1:0] fill_idx_o,
  output logic                          done_o,
  output logic                          err_o,
  axi_line_if.master                    m
);
  localparam int CW = $clog2(LINE_BEATS);
  localparam logic [AXI_ADDR_WIDTH-1:0] AMASK = ~AXI_ADDR_WIDTH'(LINE_BEATS * 8 - 1);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, fill_idx_q;
  logic [AXI_ADDR_WIDTH-1:0] wb_addr_q, fill_addr_q;
  logic [AXI_DATA_WIDTH-1:0] fill_data_q;
  logic err_q, err_d, cmd_ready_q, done_q, err_o_q, fill_valid_q;
  logic accept, last_beat, rd_hs;
  assign accept    = state_q == IDLE && cmd_valid_i && cmd_ready_q;
  assign last_beat = cnt_q == CW'(LINE_BEATS - 1);
  assign rd_hs     = state_q == R && m.rvalid;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = cmd_wb_i ? AW : AR;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      AW: if (m.awready) state_d = W;
      W: if (wb_valid_i && m.wready) begin
        cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = B;
      end
      B: if (m.bvalid) begin
        state_d = AR;
        err_d   = err_q | (m.bresp != 2'b00);
      end
      AR: if (m.arready) state_d = R;
      R: if (m.rvalid) begin
        cnt_d = cnt_q + 1'b1;
        // RLAST must coincide with the final beat index; early, missing or late RLAST all flag
        err_d = err_q | (m.rresp != 2'b00) | (m.rlast != last_beat);
        if (m.rlast) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wb_addr_q    <= '0;
      fill_addr_q  <= '0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      err_o_q      <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_data_q  <= '0;
      fill_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      cmd_ready_q  <= state_d == IDLE && state_q != DONE;
      done_q       <= state_q == DONE;
      err_o_q      <= state_q == DONE && err_q;
      fill_valid_q <= rd_hs;
      if (accept) begin
        wb_addr_q   <= cmd_wb_addr_i & AMASK;
        fill_addr_q <= cmd_fill_addr_i & AMASK;
      end
      if (rd_hs) begin
        fill_data_q <= m.rdata;
        fill_idx_q  <= cnt_q;
      end
    end
  assign cmd_ready_o  = cmd_ready_q;
  assign wb_ready_o   = state_q == W && m.wready;
  assign fill_data_o  = fill_data_q;
  assign fill_valid_o = fill_valid_q;
  assign fill_idx_o   = fill_idx_q;
  assign done_o       = done_q;
  assign err_o        = err_o_q;
  assign m.awaddr     = wb_addr_q;
  assign m.awvalid    = state_q == AW;
  assign m.awid       = '0;
  assign m.awburst    = 2'b01;
  assign m.awsize     = 3'd3;
  assign m.awlen      = 8'(LINE_BEATS - 1);
  assign m.wdata      = state_q == W ? wb_data_i : '0;
  assign m.wstrb      = '1;
  assign m.wvalid     = state_q == W && wb_valid_i;
  assign m.wlast      = state_q == W && last_beat;
  assign m.bready     = state_q == B;
  assign m.araddr     = fill_addr_q;
  assign m.arvalid    = state_q == AR;
  assign m.arid       = '0;
  assign m.arburst    = 2'b01;
  assign m.arsize     = 3'd3;
  assign m.arlen      = 8'(LINE_BEATS - 1);
  assign m.rready     = state_q == R;
endmodule

// File: tb/tb_axi_line_ctrl.sv
// tb_axi_line_ctrl: directed vector table driving a scripted AXI slave around axi_line_ctrl.
module tb_axi_line_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wb;
  logic [31:0] cmd_wb_addr, cmd_fill_addr;
  logic [63:0] wb_data;
  logic        wb_valid, wb_ready;
  logic [63:0] fill_data;
  logic        fill_valid;
  logic [1:0]  fill_idx;
  logic        done, err;
  int          errors = 0, checks = 0, cur = 0;
  axi_line_if #(.AW(32), .DW(64), .IW(4)) m ();
  axi_line_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wb_i(cmd_wb),
    .cmd_wb_addr_i(cmd_wb_addr), .cmd_fill_addr_i(cmd_fill_addr),
    .wb_data_i(wb_data), .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
    .fill_data_o(fill_data), .fill_valid_o(fill_valid), .fill_idx_o(fill_idx),
    .done_o(done), .err_o(err), .m(m)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] fill_addr;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    int          rlast_beat;
    logic [31:0] exp_awaddr;
    logic [31:0] exp_araddr;
    logic        exp_err;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h expected %h", cur, name, act, exp);
    end
  endtask
  task automatic chk_fill(input int k);
    chk("fill_valid", 64'(fill_valid), 1);
    chk("fill_idx", 64'(fill_idx), 64'(k % 4));
    chk("fill_data", fill_data, 64'h11 * 64'(k + 1));
  endtask
  task automatic run_vec(input vec_t v);
    int cyc, beats;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_wb = v.wb; cmd_wb_addr = v.wb_addr; cmd_fill_addr = v.fill_addr;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", 64'(cmd_ready), 0);
    if (v.wb) begin
      chk("awlen", 64'(m.awlen), 3);
      chk("awsize", 64'(m.awsize), 3);
      chk("awburst", 64'(m.awburst), 1);
      chk("awid", 64'(m.awid), 0);
      cyc = 0;
      while (m.awvalid && cyc < 50) begin
        cyc++;
        chk("awaddr", 64'(m.awaddr), 64'(v.exp_awaddr));
        m.awready = cyc > v.aw_dly;
        @(negedge clk);
      end
      m.awready = 1'b0;
      chk("aw_cycles", 64'(cyc), 64'(v.aw_dly + 1));
      chk("wstrb", 64'(m.wstrb), 64'hFF);
      cyc = 0; beats = 0;
      while (beats < 4 && cyc < 50) begin
        cyc++;
        wb_valid = 1'b1; wb_data = 64'hA000 + 64'(beats); m.wready = cyc > v.w_dly;
        #1;
        if (m.wvalid && m.wready) begin
          chk("wb_ready", 64'(wb_ready), 1);
          chk("wlast", 64'(m.wlast), 64'(beats == 3));
          chk("wdata", m.wdata, 64'hA000 + 64'(beats));
          beats++;
        end
        @(negedge clk);
      end
      wb_valid = 1'b0; m.wready = 1'b0;
      chk("w_beats", 64'(beats), 4);
      chk("bready", 64'(m.bready), 1);
      m.bvalid = 1'b1; m.bresp = v.bresp;
      @(negedge clk);
      m.bvalid = 1'b0; m.bresp = 2'b00;
      chk("bready_drop", 64'(m.bready), 0);
    end
    chk("arvalid", 64'(m.arvalid), 1);
    chk("araddr", 64'(m.araddr), 64'(v.exp_araddr));
    chk("arlen", 64'(m.arlen), 3);
    chk("arsize", 64'(m.arsize), 3);
    chk("arburst", 64'(m.arburst), 1);
    chk("arid", 64'(m.arid), 0);
    m.arready = 1'b1;
    @(negedge clk);
    m.arready = 1'b0;
    chk("arvalid_drop", 64'(m.arvalid), 0);
    for (int i = 0; i <= v.rlast_beat; i++) begin
      chk("rready", 64'(m.rready), 1);
      if (i > 0) chk_fill(i - 1);
      m.rvalid = 1'b1; m.rdata = 64'h11 * 64'(i + 1);
      m.rlast = i == v.rlast_beat; m.rresp = i == 0 ? v.rresp : 2'b00;
      @(negedge clk);
    end
    m.rvalid = 1'b0; m.rlast = 1'b0; m.rresp = 2'b00;
    chk_fill(v.rlast_beat);
    chk("done_early", 64'(done), 0);
    chk("rready_drop", 64'(m.rready), 0);
    @(negedge clk);
    chk("fill_valid_drop", 64'(fill_valid), 0);
    chk("done", 64'(done), 1);
    chk("err", 64'(err), 64'(v.exp_err));
    chk("cmd_ready_at_done", 64'(cmd_ready), 0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 0);
    chk("err_pulse", 64'(err), 0);
    chk("cmd_ready_after", 64'(cmd_ready), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1'b0, 32'h0, 32'h8000_0000, 0, 0, 2'b00, 2'b00, 3, 32'h0, 32'h8000_0000, 1'b0};
    vecs[1] = '{1'b1, 32'h40, 32'h0000_1000, 2, 2, 2'b00, 2'b00, 3, 32'h40, 32'h0000_1000, 1'b0};
    vecs[2] = '{1'b1, 32'h85, 32'h0000_2000, 0, 0, 2'b10, 2'b00, 3, 32'h80, 32'h0000_2000, 1'b1};
    vecs[3] = '{1'b0, 32'h0, 32'h0000_3000, 0, 0, 2'b00, 2'b00, 1, 32'h0, 32'h0000_3000, 1'b1};
    vecs[4] = '{1'b0, 32'h0, 32'h1234_5677, 0, 0, 2'b00, 2'b00, 3, 32'h0, 32'h1234_5660, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 32'h0000_4000, 0, 0, 2'b00, 2'b00, 5, 32'h0, 32'h0000_4000, 1'b1};
    vecs[6] = '{1'b0, 32'h0, 32'h0000_5000, 0, 0, 2'b00, 2'b10, 3, 32'h0, 32'h0000_5000, 1'b1};
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_wb = 1'b0; cmd_wb_addr = '0; cmd_fill_addr = '0;
    wb_data = '0; wb_valid = 1'b0;
    m.awready = 1'b0; m.wready = 1'b0; m.bvalid = 1'b0; m.bresp = 2'b00; m.bid = '0;
    m.arready = 1'b0; m.rvalid = 1'b0; m.rdata = '0; m.rresp = 2'b00; m.rid = '0; m.rlast = 1'b0;
    cur = 100;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 0);
    chk("rst_awvalid", 64'(m.awvalid), 0);
    chk("rst_arvalid", 64'(m.arvalid), 0);
    chk("rst_wvalid", 64'(m.wvalid), 0);
    chk("rst_wlast", 64'(m.wlast), 0);
    chk("rst_bready", 64'(m.bready), 0);
    chk("rst_rready", 64'(m.rready), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_fill_valid", 64'(fill_valid), 0);
    chk("rst_araddr", 64'(m.araddr), 0);
    chk("rst_fill_data", fill_data, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end
    cur = 101;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wb = 1'b1; cmd_wb_addr = 32'h100; cmd_fill_addr = 32'h6000;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_awvalid", 64'(m.awvalid), 1);
    m.awready = 1'b1;
    @(negedge clk);
    m.awready = 1'b0;
    wb_valid = 1'b1; wb_data = 64'hBEEF; m.wready = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_beat1_wvalid", 64'(m.wvalid), 1);
    chk("mid_beat1_wlast", 64'(m.wlast), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wvalid", 64'(m.wvalid), 0);
    chk("mid_rst_wb_ready", 64'(wb_ready), 0);
    chk("mid_rst_wdata", m.wdata, 0);
    chk("mid_rst_awaddr", 64'(m.awaddr), 0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 0);
    chk("mid_rst_done", 64'(done), 0);
    wb_valid = 1'b0; m.wready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 1);
    chk("post_rst_done", 64'(done), 0);
    cur = 1;
    run_vec(vecs[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
